pipe_stage_skid: RTL
====================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the payload width (PC and instruction concatenated).
REQ-002 Parameter BUBBLE_VAL, default all-zero DATA_W bits, SHALL set the out_data value presented when no entry is valid.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall_cnt width.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port flush, input, 1 bit: discard all held entries and insert a bubble.
REQ-007 Port in_valid, input, 1 bit: upstream payload valid.
REQ-008 Port in_data, input, DATA_W bits: upstream payload.
REQ-009 Port in_ready, output, 1 bit: stage can accept an entry.
REQ-010 Port out_valid, output, 1 bit: out_data holds a real entry.
REQ-011 Port out_data, output, DATA_W bits: downstream payload.
REQ-012 Port out_ready, input, 1 bit: downstream accepts the entry.
REQ-013 Port occupancy, output, 2 bits: number of held entries (0..2).
REQ-014 Port stall_cnt, output, CNT_W bits: saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-016 Storage SHALL be a main register and a skid register; FSM states: EMPTY (0 held), BUSY (main held), FULL (main and skid held).
REQ-017 in_ready SHALL be 1 in EMPTY and BUSY and 0 in FULL, decoded from state only, with no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 in BUSY and FULL; out_data SHALL be main in BUSY and FULL, and BUBBLE_VAL in EMPTY.
REQ-019 occupancy SHALL be 0, 1 or 2 for EMPTY, BUSY or FULL respectively.
REQ-020 EMPTY with in_fire: main <= in_data, go to BUSY; the entry is visible at out_data 1 cycle later.
REQ-021 BUSY with in_fire and out_fire: main <= in_data, stay in BUSY.
REQ-022 BUSY with in_fire and no out_fire: skid <= in_data, go to FULL; main is unchanged.
REQ-023 BUSY with out_fire and no in_fire: go to EMPTY.
REQ-024 FULL with out_fire: main <= skid, go to BUSY; no input is accepted in this cycle (in_ready=0).
REQ-025 With no fire events, state, main and skid SHALL hold.
REQ-026 Entry order SHALL be strictly FIFO; no entry is duplicated or lost except by flush.
REQ-027 flush=1 SHALL take priority over all events.
REQ-028 On flush the next state SHALL be EMPTY and both entries SHALL be discarded.
REQ-029 An in_fire in the same cycle as flush SHALL be discarded.
REQ-030 An out_fire in the same cycle as flush SHALL still count as consumed downstream.
REQ-031 stall_cnt SHALL increment when out_valid=1 and out_ready=0, and SHALL saturate at 2^CNT_W-1.
REQ-032 flush SHALL NOT clear stall_cnt.

Reset
REQ-033 rst=0 SHALL immediately, without waiting for a clock edge, force: state EMPTY, main = skid = BUBBLE_VAL, stall_cnt = 0, out_valid = 0, in_ready = 1, occupancy = 0, out_data = BUBBLE_VAL.
REQ-034 A reset asserted mid-operation SHALL discard all held entries.
REQ-035 The first in_fire SHALL be accepted on the first rising clk edge after rst is released.

Verification
REQ-036 Stream: out_ready=1 throughout; in_data 1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later each; occupancy stays at 1; stall_cnt = 0.
REQ-037 Backpressure: out_ready=0; push 0xA then 0xB -> occupancy 2, in_ready=0, out_data=0xA; then out_ready=1 -> 0xA then 0xB drain in order, finishing at occupancy 0.
REQ-038 Flush while FULL, with in_valid=1 carrying 0xC -> next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy 0; 0xC never appears at out_data.
REQ-039 Saturation: CNT_W=4; hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and holds at 15.
REQ-040 Async reset: assert rst=0 between clock edges while FULL -> outputs take their REQ-033 values before the next edge; after release, a push of 0x5 appears at out_data 1 cycle later.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage (main + skid register) with flush,
// bubble insertion on empty, and a saturating downstream-stall counter.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | nothing held, out_data shows BUBBLE_VAL
// ST_BUSY  | main holds the head entry
// ST_FULL  | main holds the head entry, skid holds the next
module pipe_stage_skid #(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;
  logic              stall;

  // Handshake outputs decode from state only, so in_ready never sees out_ready.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_data  = BUBBLE_VAL;
    occupancy = 2'd0;
    case (state_q)
      ST_EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_data  = BUBBLE_VAL;
        occupancy = 2'd0;
      end
      ST_BUSY: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        out_data  = main_q;
        occupancy = 2'd1;
      end
      ST_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        out_data  = main_q;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_data  = BUBBLE_VAL;
        occupancy = 2'd0;
      end
    endcase
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign stall    = out_valid & ~out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Any entry handed downstream this cycle is already gone; the rest is dropped.
      state_d = ST_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_BUSY;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Stall count survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
